// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbitrated shared register.
package dff_bank_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Wide enough for any supported counter width; the top slices it to CNT_W.
  localparam logic [63:0] CNT_SAT = '1;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Requester bus and shared-register outputs of dff_bank_arbiter.
interface dff_bank_arbiter_if
  import dff_bank_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16
);
  localparam int IW = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_lock;
  logic [NUM_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]         q;
  logic                     q_valid;
  logic [IW-1:0]            grant_id;
  logic [CNT_W-1:0]         write_count;
  logic                     locked;

  modport master (
    output req_valid, req_data, req_lock,
    input  req_ready, q, q_valid, grant_id, write_count, locked
  );

  modport slave (
    input  req_valid, req_data, req_lock,
    output req_ready, q, q_valid, grant_id, write_count, locked
  );

endinterface

// File: rtl/dff_bank_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after start, circularly.
module rr_picker
  import dff_bank_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  localparam logic [IW:0] N_EXT = (IW+1)'(N);

  logic [IW:0]   sum;
  logic [IW-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, start} + (IW+1)'(k);
      pos = (sum >= N_EXT) ? IW'(sum - N_EXT) : IW'(sum);
      if (req[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_grant
      assign grant[gi] = found && (idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbitrated shared DFF register with saturating write counter.
// Optional lock support is enabled by defining DFF_BANK_ARB_LOCK_EN.
module dff_bank_arbiter
  import dff_bank_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  dff_bank_arbiter_if.slave bus
);

  localparam int             IW       = idx_width(NUM_REQ);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] SAT    = CNT_SAT[CNT_W-1:0];

  state_t             state_reg, state_next;
  logic [IW-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_found;
  logic [NUM_REQ-1:0] ready;
  logic [IW-1:0]      win_idx;
  logic               xfer;

  logic [WIDTH-1:0]   q_reg;
  logic               q_valid_reg;
  logic [IW-1:0]      grant_id_reg;
  logic [CNT_W-1:0]   write_count_reg;

`ifdef DFF_BANK_ARB_LOCK_EN
  logic [IW-1:0]      owner_reg, owner_next;
`else
  logic               unused_lock;
  assign unused_lock = ^bus.req_lock;
`endif

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == LAST_IDX) ? '0 : IW'(i + 1'b1);
  endfunction

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .req   (bus.req_valid),
    .start (rr_ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    ready       = '0;
    win_idx     = pick_idx;
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
`ifdef DFF_BANK_ARB_LOCK_EN
    owner_next  = owner_reg;
`endif
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          ready = pick_grant;
          if (pick_found) begin
            rr_ptr_next = next_idx(pick_idx);
`ifdef DFF_BANK_ARB_LOCK_EN
            if (bus.req_lock[pick_idx]) begin
              state_next = LOCKED;
              owner_next = pick_idx;
            end
`endif
          end
        end
`ifdef DFF_BANK_ARB_LOCK_EN
        LOCKED: begin
          // Only the owner may write; releasing lock (with or without a final write) exits.
          ready[owner_reg] = bus.req_valid[owner_reg];
          win_idx          = owner_reg;
          if (!bus.req_lock[owner_reg]) begin
            state_next  = IDLE;
            rr_ptr_next = next_idx(owner_reg);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign xfer = |(bus.req_valid & ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
`ifdef DFF_BANK_ARB_LOCK_EN
      owner_reg  <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
`ifdef DFF_BANK_ARB_LOCK_EN
      owner_reg  <= owner_next;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg           <= '0;
      q_valid_reg     <= 1'b0;
      grant_id_reg    <= '0;
      write_count_reg <= '0;
    end else begin
      q_valid_reg <= xfer;
      if (xfer) begin
        q_reg        <= bus.req_data[win_idx*WIDTH +: WIDTH];
        grant_id_reg <= win_idx;
        if (write_count_reg != SAT)
          write_count_reg <= write_count_reg + 1'b1;
      end
    end
  end

  assign bus.req_ready   = ready;
  assign bus.q           = q_reg;
  assign bus.q_valid     = q_valid_reg;
  assign bus.grant_id    = grant_id_reg;
  assign bus.write_count = write_count_reg;
`ifdef DFF_BANK_ARB_LOCK_EN
  assign bus.locked      = (state_reg == LOCKED);
`else
  assign bus.locked      = 1'b0;
`endif

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed self-checking bench for dff_bank_arbiter (NUM_REQ=4, WIDTH=8, CNT_W=4).
module tb_dff_bank_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int CNT_W   = 4;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  dff_bank_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  dff_bank_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [WIDTH-1:0] d);
    bus.req_data[i*WIDTH +: WIDTH] = d;
  endtask

  initial begin
    int exp_g;
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.req_data  = '0;
    bus.req_lock  = '0;
    #2;
    check("rst_q",       64'(bus.q),           64'h0);
    check("rst_q_valid", 64'(bus.q_valid),     64'h0);
    check("rst_gid",     64'(bus.grant_id),    64'h0);
    check("rst_cnt",     64'(bus.write_count), 64'h0);
    check("rst_locked",  64'(bus.locked),      64'h0);
    check("rst_ready",   64'(bus.req_ready),   64'h0);
    tick();
    bus.req_valid = '0;
    rst = 1'b0;
    #1;

    // Single requester 2
    set_data(2, 8'h3C);
    bus.req_valid = 4'b0100;
    #1;
    check("single_ready", 64'(bus.req_ready), 64'b0100);
    tick();
    check("single_q",   64'(bus.q),           64'h3C);
    check("single_qv",  64'(bus.q_valid),     64'h1);
    check("single_gid", 64'(bus.grant_id),    64'h2);
    check("single_cnt", 64'(bus.write_count), 64'h1);
    bus.req_valid = '0;
    tick();
    check("idle_qv",   64'(bus.q_valid), 64'h0);
    check("idle_hold", 64'(bus.q),       64'h3C);

    // rr_ptr is 3: wrap from 3 to 0
    set_data(0, 8'h11);
    set_data(3, 8'h33);
    bus.req_valid = 4'b1001;
    #1;
    check("wrap_ready3", 64'(bus.req_ready), 64'b1000);
    tick();
    check("wrap_q3",     64'(bus.q),         64'h33);
    check("wrap_gid3",   64'(bus.grant_id),  64'h3);
    check("wrap_ready0", 64'(bus.req_ready), 64'b0001);
    tick();
    check("wrap_q0",   64'(bus.q),           64'h11);
    check("wrap_gid0", 64'(bus.grant_id),    64'h0);
    check("wrap_cnt",  64'(bus.write_count), 64'h3);

    // Move rr_ptr back to 0 via requester 3
    bus.req_valid = 4'b1000;
    tick();
    check("realign_gid", 64'(bus.grant_id), 64'h3);

    // All requesting continuously: 0,1,2,3,0
    for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'(8'h40 + i));
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = k % NUM_REQ;
      #1;
      check("all_ready", 64'(bus.req_ready), 64'(1 << exp_g));
      tick();
      check("all_gid", 64'(bus.grant_id), 64'(exp_g));
      check("all_q",   64'(bus.q),        64'(8'h40 + exp_g));
      check("all_qv",  64'(bus.q_valid),  64'h1);
    end
    check("all_cnt", 64'(bus.write_count), 64'h9);

    // Asynchronous reset mid-operation with q=A5
    set_data(1, 8'hA5);
    bus.req_valid = 4'b0010;
    #1;
    check("pre_rst_ready", 64'(bus.req_ready), 64'b0010);
    tick();
    check("pre_rst_q", 64'(bus.q), 64'hA5);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_q",     64'(bus.q),           64'h0);
    check("async_rst_qv",    64'(bus.q_valid),     64'h0);
    check("async_rst_cnt",   64'(bus.write_count), 64'h0);
    check("async_rst_ready", 64'(bus.req_ready),   64'h0);
    bus.req_valid = '0;
    #1;
    rst = 1'b0;
    tick();

    // Saturation at 4'hF over 20 writes
    bus.req_valid = 4'b1111;
    for (int n = 1; n <= 20; n++) begin
      tick();
      check("sat_cnt", 64'(bus.write_count), 64'((n < 15) ? n : 15));
    end
    bus.req_valid = '0;
    tick();
    check("sat_qv_off", 64'(bus.q_valid), 64'h0);

`ifdef DFF_BANK_ARB_LOCK_EN
    // rr_ptr is 0; requester 0 writes once so the pointer lands on 1
    set_data(0, 8'h55);
    bus.req_valid = 4'b0001;
    tick();
    set_data(1, 8'h77);
    bus.req_valid = 4'b0011;
    bus.req_lock  = 4'b0010;
    #1;
    check("lock_ready1", 64'(bus.req_ready), 64'b0010);
    tick();
    check("lock_locked", 64'(bus.locked),    64'h1);
    check("lock_q",      64'(bus.q),         64'h77);
    check("lock_stall0", 64'(bus.req_ready), 64'b0010);
    set_data(1, 8'h78);
    bus.req_lock = 4'b0000;
    #1;
    check("unlock_ready1", 64'(bus.req_ready), 64'b0010);
    tick();
    check("unlock_locked", 64'(bus.locked),    64'h0);
    check("unlock_q",      64'(bus.q),         64'h78);
    check("unlock_gid",    64'(bus.grant_id),  64'h1);
    check("unlock_ready0", 64'(bus.req_ready), 64'b0001);
    tick();
    check("after_gid", 64'(bus.grant_id), 64'h0);
    check("after_q",   64'(bus.q),        64'h55);
`else
    // Lock requests are ignored: no lock, round robin continues
    set_data(1, 8'h77);
    bus.req_valid = 4'b0010;
    bus.req_lock  = 4'b0010;
    tick();
    check("nolock_locked", 64'(bus.locked), 64'h0);
    check("nolock_q",      64'(bus.q),      64'h77);
    bus.req_valid = 4'b0011;
    #1;
    check("nolock_ready", 64'(bus.req_ready), 64'b0001);
`endif
    bus.req_valid = '0;
    bus.req_lock  = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
